// File: rtl/stack_pkg.sv
// Shared types and constants for the stack request controller.
package stack_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        REPLACE = 1'b1
    } stack_state_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Request-side controller for the shift-register stack: occupancy tracking,
// over/underflow refusal with sticky flags, registered pop result and a
// two-cycle replace-top (pop then push) sequence.
//
// state   | meaning
// IDLE    | accepting push/pop requests
// REPLACE | second half of push+pop: loading the held value, requests dropped
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                               sysclk,
    input  logic                               sysreset_n,
    input  logic                               push_req,
    input  logic                               pop_req,
    input  logic [DATA_W-1:0]                  push_data,
    input  logic                               err_clear,
    output logic                               busy,
    output logic [DATA_W-1:0]                  pop_data,
    output logic                               pop_valid,
    output logic [DATA_W-1:0]                  top,
    output logic [count_width(DEPTH)-1:0]      count,
    output logic                               empty,
    output logic                               full,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               stk_load,
    output logic                               stk_read,
    output logic [DATA_W-1:0]                  stk_data_in,
    input  logic [DATA_W-1:0]                  stk_data_out
);

    localparam int                CNT_W    = count_width(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);

    stack_state_t      state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              empty_q, full_q, busy_q;
    logic              overflow_q, underflow_q;
    logic              ovf_set, unf_set;

    // Request decode: next state, counters, strobes toward the stack.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hold_d      = hold_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        stk_load    = 1'b0;
        stk_read    = 1'b0;
        stk_data_in = push_data;
        case (state_q)
            IDLE: begin
                if (push_req && pop_req) begin
                    if (!empty_q) begin
                        // count is left alone: the pop and the later push cancel out
                        stk_read    = 1'b1;
                        pop_data_d  = stk_data_out;
                        pop_valid_d = 1'b1;
                        hold_d      = push_data;
                        state_d     = REPLACE;
                    end else begin
                        // nothing to pop: degrade to a plain push (DEPTH >= 2, so never full here)
                        stk_load = 1'b1;
                        count_d  = count_q + ONE_CNT;
                        unf_set  = 1'b1;
                    end
                end else if (push_req) begin
                    if (!full_q) begin
                        stk_load = 1'b1;
                        count_d  = count_q + ONE_CNT;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (pop_req) begin
                    if (!empty_q) begin
                        stk_read    = 1'b1;
                        pop_data_d  = stk_data_out;
                        pop_valid_d = 1'b1;
                        count_d     = count_q - ONE_CNT;
                    end else begin
                        unf_set = 1'b1;
                    end
                end
            end
            REPLACE: begin
                stk_load    = 1'b1;
                stk_data_in = hold_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // keep the stack quiet while reset is held, whatever the requester drives
        if (!sysreset_n) begin
            stk_load = 1'b0;
            stk_read = 1'b0;
        end
    end

    // State and registered outputs; sticky flags favour set over clear.
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            hold_q      <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == FULL_CNT);
            busy_q      <= (state_d == REPLACE);
            overflow_q  <= ovf_set | (overflow_q  & ~err_clear);
            underflow_q <= unf_set | (underflow_q & ~err_clear);
        end
    end

    assign busy      = busy_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign top       = stk_data_out;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl with a behavioural shift-register stack beside it.
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = count_width(DEPTH);

    logic              clk, rst_n;
    logic              push_req, pop_req, err_clear;
    logic [15:0]       push_data;
    logic              busy, pop_valid, empty, full, overflow, underflow;
    logic [15:0]       pop_data, top, stk_data_in, stk_data_out;
    logic [CW-1:0]     count;
    logic              stk_load, stk_read;

    int total = 0;
    int bad   = 0;

    stack_ctrl #(.DEPTH(DEPTH)) dut (
        .sysclk      (clk),
        .sysreset_n  (rst_n),
        .push_req    (push_req),
        .pop_req     (pop_req),
        .push_data   (push_data),
        .err_clear   (err_clear),
        .busy        (busy),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .top         (top),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow),
        .stk_load    (stk_load),
        .stk_read    (stk_read),
        .stk_data_in (stk_data_in),
        .stk_data_out(stk_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shift-register stack sharing the controller's reset.
    logic [15:0] mem [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (stk_load) begin
            for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= stk_data_in;
        end else if (stk_read) begin
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
        end
    end
    assign stk_data_out = mem[0];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    typedef struct {
        logic        push, pop, clr;
        logic [15:0] data;
        logic        e_load, e_read;
        logic [15:0] e_din;
        int          e_cnt;
        logic [15:0] e_top;
        logic        e_pv;
        logic [15:0] e_pd;
        logic        e_ovf, e_unf, e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic push, logic pop, logic clr, logic [15:0] data,
                                logic e_load, logic e_read, logic [15:0] e_din,
                                int e_cnt, logic [15:0] e_top, logic e_pv, logic [15:0] e_pd,
                                logic e_ovf, logic e_unf, logic e_busy);
        vec_t v;
        v.push = push; v.pop = pop; v.clr = clr; v.data = data;
        v.e_load = e_load; v.e_read = e_read; v.e_din = e_din;
        v.e_cnt = e_cnt; v.e_top = e_top; v.e_pv = e_pv; v.e_pd = e_pd;
        v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic drive(input logic push, input logic pop, input logic clr, input logic [15:0] data);
        push_req  = push;
        pop_req   = pop;
        err_clear = clr;
        push_data = data;
    endtask

    task automatic chk_regs(input string tag, input int row, input int e_cnt, input logic [15:0] e_top,
                            input logic e_pv, input logic [15:0] e_pd,
                            input logic e_ovf, input logic e_unf, input logic e_busy);
        chk({tag, ".count"},     row, 32'(count),     32'(e_cnt));
        chk({tag, ".top"},       row, 32'(top),       32'(e_top));
        chk({tag, ".pop_valid"}, row, 32'(pop_valid), 32'(e_pv));
        chk({tag, ".pop_data"},  row, 32'(pop_data),  32'(e_pd));
        chk({tag, ".overflow"},  row, 32'(overflow),  32'(e_ovf));
        chk({tag, ".underflow"}, row, 32'(underflow), 32'(e_unf));
        chk({tag, ".busy"},      row, 32'(busy),      32'(e_busy));
        chk({tag, ".empty"},     row, 32'(empty),     32'(e_cnt == 0));
        chk({tag, ".full"},      row, 32'(full),      32'(e_cnt == DEPTH));
    endtask

    task automatic chk_strobes(input string tag, input int row, input logic e_load, input logic e_read,
                               input logic [15:0] e_din);
        chk({tag, ".stk_load"}, row, 32'(stk_load), 32'(e_load));
        chk({tag, ".stk_read"}, row, 32'(stk_read), 32'(e_read));
        if (e_load) chk({tag, ".stk_data_in"}, row, 32'(stk_data_in), 32'(e_din));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0);

        // Directed table: basic LIFO, underflow, overflow, replace.
        vecs.push_back(mk(1,0,0,16'h1111, 1,0,16'h1111, 1,16'h1111, 0,16'h0000, 0,0,0));
        vecs.push_back(mk(1,0,0,16'h2222, 1,0,16'h2222, 2,16'h2222, 0,16'h0000, 0,0,0));
        vecs.push_back(mk(1,0,0,16'h3333, 1,0,16'h3333, 3,16'h3333, 0,16'h0000, 0,0,0));
        vecs.push_back(mk(0,1,0,16'h0000, 0,1,16'h0000, 2,16'h2222, 1,16'h3333, 0,0,0));
        vecs.push_back(mk(0,1,0,16'h0000, 0,1,16'h0000, 1,16'h1111, 1,16'h2222, 0,0,0));
        vecs.push_back(mk(0,1,0,16'h0000, 0,1,16'h0000, 0,16'h0000, 1,16'h1111, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 0,16'h1111, 0,0,0));
        vecs.push_back(mk(0,1,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 0,16'h1111, 0,1,0));
        vecs.push_back(mk(0,1,1,16'h0000, 0,0,16'h0000, 0,16'h0000, 0,16'h1111, 0,1,0));
        vecs.push_back(mk(0,0,1,16'h0000, 0,0,16'h0000, 0,16'h0000, 0,16'h1111, 0,0,0));
        for (int i = 1; i <= DEPTH; i++)
            vecs.push_back(mk(1,0,0,16'(i), 1,0,16'(i), i,16'(i), 0,16'h1111, 0,0,0));
        vecs.push_back(mk(1,0,0,16'hDEAD, 0,0,16'h0000, 8,16'h0008, 0,16'h1111, 1,0,0));
        vecs.push_back(mk(0,0,1,16'h0000, 0,0,16'h0000, 8,16'h0008, 0,16'h1111, 0,0,0));
        vecs.push_back(mk(0,1,0,16'h0000, 0,1,16'h0000, 7,16'h0007, 1,16'h0008, 0,0,0));
        vecs.push_back(mk(1,0,0,16'hAAAA, 1,0,16'hAAAA, 8,16'hAAAA, 0,16'h0008, 0,0,0));
        vecs.push_back(mk(1,1,0,16'hBBBB, 0,1,16'h0000, 8,16'h0007, 1,16'hAAAA, 0,0,1));
        vecs.push_back(mk(1,0,0,16'hCCCC, 1,0,16'hBBBB, 8,16'hBBBB, 0,16'hAAAA, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 8,16'hBBBB, 0,16'hAAAA, 0,0,0));

        repeat (2) @(posedge clk);
        #1;
        chk_regs("reset", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        chk_strobes("reset", 0, 0, 0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[r]) begin
            @(negedge clk);
            drive(vecs[r].push, vecs[r].pop, vecs[r].clr, vecs[r].data);
            #1;
            chk_strobes("vec", r, vecs[r].e_load, vecs[r].e_read, vecs[r].e_din);
            @(posedge clk);
            #1;
            chk_regs("vec", r, vecs[r].e_cnt, vecs[r].e_top, vecs[r].e_pv, vecs[r].e_pd,
                     vecs[r].e_ovf, vecs[r].e_unf, vecs[r].e_busy);
        end

        // Fresh reset, then push+pop on an empty stack degrades to a push.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 16'h5555);
        #1;
        chk_strobes("pp_empty", 0, 1, 0, 16'h5555);
        @(posedge clk);
        #1;
        chk_regs("pp_empty", 0, 1, 16'h5555, 0, 16'h0000, 0, 1, 0);

        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 16'h6666);
        @(posedge clk);
        #1;
        chk_regs("pp_push", 0, 2, 16'h6666, 0, 16'h0000, 0, 1, 0);

        // Start a replace, then hit reset while it is in flight.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h7777);
        @(posedge clk);
        #1;
        chk_regs("rst_rep", 0, 2, 16'h5555, 1, 16'h6666, 0, 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_regs("rst_mid", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        chk_strobes("rst_mid", 0, 0, 0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_regs("rst_after", 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        chk_strobes("rst_after", 0, 0, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
